cacheline_adaptor: RTL and testbench
====================================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 address_i  input  32  line request address from L2 side (byte address).
REQ-004 read_i  input  1  line read request; level, held until resp_o.
REQ-005 write_i  input  1  line write request; level, held until resp_o.
REQ-006 line_i  input  256  write line data; valid while write_i high.
REQ-007 line_o  output  256  read line data; valid in resp_o cycle after a read.
REQ-008 resp_o  output  1  one-cycle completion pulse to L2 side.
REQ-009 address_o  output  32  burst address to memory, line-aligned.
REQ-010 read_o  output  1  burst read request to memory.
REQ-011 write_o  output  1  burst write request to memory.
REQ-012 burst_o  output  64  write beat data to memory.
REQ-013 burst_i  input  64  read beat data from memory.
REQ-014 resp_i  input  1  memory beat acknowledge; one beat transferred per cycle resp_i high.

Function
REQ-015 The block SHALL convert one 256-bit line transfer into a 4-beat 64-bit memory burst; beat k carries line bits [64k+63:64k], k=0 first.
REQ-016 The FSM SHALL have states IDLE, RD, WR, DONE.
REQ-017 In IDLE, read_i=1 SHALL accept a read: latch {address_i[31:5],5'b0} into address_o, clear beat counter, go to RD.
REQ-018 In IDLE, write_i=1 with read_i=0 SHALL accept a write: latch aligned address and line_i, clear beat counter, go to WR.
REQ-019 read_i and write_i both high in IDLE SHALL be treated as a read; write ignored.
REQ-020 In RD, read_o SHALL be 1; each cycle with resp_i=1 SHALL store burst_i into line_o beat slot [counter] and increment the 2-bit counter.
REQ-021 In WR, write_o SHALL be 1 and burst_o SHALL equal latched line beat [counter]; each cycle with resp_i=1 SHALL increment counter.
REQ-022 resp_i=0 in RD/WR SHALL stall: counter, line_o, burst_o, address_o unchanged, read_o/write_o held.
REQ-023 The cycle the 4th beat (counter=3) is acknowledged SHALL transition to DONE; read_o/write_o SHALL be 0 from the next cycle.
REQ-024 In DONE, resp_o SHALL be 1 for exactly that cycle; next state IDLE unconditionally; a request seen in DONE SHALL NOT be accepted.
REQ-025 Minimum latency: accept at cycle t, read_o/write_o high t+1..t+4 with resp_i continuously high, resp_o at t+5.
REQ-026 line_o SHALL hold the last completed read line until the next read beat 0 is captured; writes SHALL NOT change line_o.
REQ-027 resp_i while IDLE or DONE SHALL be ignored.
REQ-028 address_o SHALL remain stable from accept through DONE; low 5 bits always 0.
REQ-029 read_o and write_o SHALL never be high simultaneously.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, counter=0, resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0, line_o=0, from any state including mid-burst.
REQ-031 After rst deasserts, a request held high SHALL be accepted on the first IDLE cycle without residual beats.

Verification
REQ-032 Read, address_i=0x0000_1234, resp_i high 4 cycles with burst_i=A,B,C,D -> address_o=0x0000_1220, read_o 4 cycles, resp_o pulse at t+5, line_o={D,C,B,A}.
REQ-033 Write, line_i={W3,W2,W1,W0}, resp_i high 4 cycles -> burst_o=W0,W1,W2,W3 in order, write_o 4 cycles, resp_o one cycle, line_o unchanged.
REQ-034 Read with resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order, resp_o one cycle after 7th pattern cycle, read_o held through stalls.
REQ-035 read_i and write_i both high at accept -> read burst only, write_o stays 0.
REQ-036 rst asserted after 2 write beats -> next cycle write_o=0, resp_o=0, all outputs 0; subsequent read completes normally with 4 fresh beats.
REQ-037 read_i held high across resp_o -> no acceptance in DONE cycle; new read accepted the following IDLE cycle.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges 256-bit line requests to 4-beat 64-bit memory bursts.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  output logic         resp_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  output logic [63:0]  burst_o,
  input  logic [63:0]  burst_i,
  input  logic         resp_i
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3;
  logic [1:0]   state_q, state_d, cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] wline_q, wline_d, line_q, line_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    line_d  = line_q;
    if (state_q == IDLE && (read_i || write_i)) begin
      state_d = read_i ? RD : WR;
      cnt_d   = 2'd0;
      addr_d  = {address_i[31:5], 5'b0};
      if (!read_i) wline_d = line_i;
    end else if ((state_q == RD || state_q == WR) && resp_i) begin
      cnt_d = cnt_q + 2'd1;
      if (state_q == RD) line_d[{cnt_q, 6'b0} +: 64] = burst_i;
      if (cnt_q == 2'd3) state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      wline_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      line_q  <= line_d;
    end
  end
  assign read_o    = state_q == RD;
  assign write_o   = state_q == WR;
  assign resp_o    = state_q == DONE;
  assign address_o = addr_q;
  assign line_o    = line_q;
  assign burst_o   = write_o ? wline_q[{cnt_q, 6'b0} +: 64] : 64'd0;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed checks of line/burst conversion, stalls and reset.
module tb_cacheline_adaptor;
  logic         clk = 0, rst = 1, read_i = 0, write_i = 0, resp_i = 0;
  logic [31:0]  address_i = 0;
  logic [255:0] line_i = 0;
  logic [63:0]  burst_i = 0;
  logic [255:0] line_o;
  logic         resp_o, read_o, write_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_o;
  int nvec = 0, nerr = 0;
  localparam logic [63:0] A = 64'hAAAA_0000_1111_0001, B = 64'hBBBB_0000_2222_0002;
  localparam logic [63:0] C = 64'hCCCC_0000_3333_0003, D = 64'hDDDD_0000_4444_0004;
  localparam logic [63:0] W0 = 64'h0101_0101_0101_0101, W1 = 64'h0202_0202_0202_0202;
  localparam logic [63:0] W2 = 64'h0303_0303_0303_0303, W3 = 64'h0404_0404_0404_0404;
  localparam logic [63:0] E = 64'h1234_5678_9ABC_DEF0, F = 64'h0FED_CBA9_8765_4321;
  localparam logic [63:0] G = 64'hDEAD_BEEF_CAFE_F00D, H = 64'h5555_AAAA_5555_AAAA;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_beats(input logic [63:0] b0, b1, b2, b3);
    logic [63:0] bs [4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    for (int k = 0; k < 4; k++) begin
      chk("rd_read_o", read_o, 1);
      chk("rd_resp_o_low", resp_o, 0);
      resp_i = 1; burst_i = bs[k];
      tick();
    end
    resp_i = 0; burst_i = 0;
  endtask

  initial begin
    tick();
    chk("rst_state", {line_o[63:0], address_o, burst_o, resp_o, read_o, write_o}, 0);
    chk("rst_line", line_o, 0);
    rst = 0;
    tick();
    // plain read
    address_i = 32'h0000_1234; read_i = 1;
    tick();
    chk("rd_addr", address_o, 32'h0000_1220);
    chk("rd_wr_low", write_o, 0);
    rd_beats(A, B, C, D);
    read_i = 0;
    chk("rd_done_resp", resp_o, 1);
    chk("rd_done_read_o", read_o, 0);
    chk("rd_line", line_o, {D, C, B, A});
    chk("rd_done_addr", address_o, 32'h0000_1220);
    resp_i = 1;
    tick();
    chk("idle_resp_low", resp_o, 0);
    tick();
    chk("idle_resp_i_ignored", {resp_o, read_o, write_o}, 0);
    chk("idle_line_hold", line_o, {D, C, B, A});
    resp_i = 0;
    // plain write
    address_i = 32'hFFFF_FFFF; write_i = 1; line_i = {W3, W2, W1, W0};
    tick();
    chk("wr_addr", address_o, 32'hFFFF_FFE0);
    chk("wr_read_low", read_o, 0);
    begin
      logic [63:0] ws [4];
      ws[0] = W0; ws[1] = W1; ws[2] = W2; ws[3] = W3;
      for (int k = 0; k < 4; k++) begin
        chk("wr_write_o", write_o, 1);
        chk("wr_burst", burst_o, ws[k]);
        resp_i = 1;
        tick();
      end
    end
    write_i = 0; resp_i = 0;
    chk("wr_done_resp", resp_o, 1);
    chk("wr_done_write_o", write_o, 0);
    chk("wr_line_unchanged", line_o, {D, C, B, A});
    tick();
    chk("wr_idle_resp", resp_o, 0);
    // read with stalls 1,0,0,1,1,0,1
    address_i = 32'h8000_003F; read_i = 1;
    tick();
    chk("st_addr", address_o, 32'h8000_0020);
    begin
      logic pat [7];
      logic [63:0] bs [4];
      int n;
      pat = '{1, 0, 0, 1, 1, 0, 1};
      bs[0] = E; bs[1] = F; bs[2] = G; bs[3] = H;
      n = 0;
      for (int k = 0; k < 7; k++) begin
        chk("st_read_o", read_o, 1);
        chk("st_resp_low", resp_o, 0);
        resp_i = pat[k];
        burst_i = pat[k] ? bs[n] : 64'hBAD0_BAD0_BAD0_BAD0;
        if (pat[k]) n++;
        tick();
      end
    end
    resp_i = 0; read_i = 0;
    chk("st_done_resp", resp_o, 1);
    chk("st_line", line_o, {H, G, F, E});
    chk("st_addr_hold", address_o, 32'h8000_0020);
    tick();
    // read and write together behave as a read
    address_i = 32'h0000_ABCD; read_i = 1; write_i = 1; line_i = {4{W3}};
    tick();
    chk("both_write_o", write_o, 0);
    chk("both_addr", address_o, 32'h0000_ABC0);
    for (int k = 0; k < 4; k++) begin
      chk("both_write_o_beat", write_o, 0);
      resp_i = 1; burst_i = 64'(k + 10);
      tick();
    end
    resp_i = 0; read_i = 0; write_i = 0;
    chk("both_done", resp_o, 1);
    chk("both_line", line_o, {64'd13, 64'd12, 64'd11, 64'd10});
    tick();
    // reset in the middle of a write
    address_i = 32'h0000_0040; write_i = 1; line_i = {W0, W1, W2, W3};
    tick();
    resp_i = 1;
    tick();
    tick();
    chk("mid_write_o", write_o, 1);
    chk("mid_burst", burst_o, W1);
    rst = 1; write_i = 0; read_i = 1; address_i = 32'h0000_0100; resp_i = 0;
    tick();
    chk("mid_rst_outs", {address_o, burst_o, resp_o, read_o, write_o}, 0);
    chk("mid_rst_line", line_o, 0);
    rst = 0;
    tick();
    chk("post_rst_read", read_o, 1);
    chk("post_rst_addr", address_o, 32'h0000_0100);
    rd_beats(H, G, F, E);
    chk("post_rst_done", resp_o, 1);
    chk("post_rst_line", line_o, {E, F, G, H});
    // read_i held across resp_o: no accept in DONE
    tick();
    chk("held_idle_read_o", read_o, 0);
    chk("held_idle_resp_o", resp_o, 0);
    address_i = 32'h0000_0200;
    tick();
    chk("held_accept", read_o, 1);
    chk("held_addr", address_o, 32'h0000_0200);
    rd_beats(A, A, B, B);
    read_i = 0;
    chk("held_done", resp_o, 1);
    chk("held_line", line_o, {B, B, A, A});
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
